// File: rtl/mem_module.sv
// -----------------------------------------------------------------------------
// mem_module : memory-access pipeline stage, directly after the execute stage.
//
// Non-memory results arriving on exbus pass through to membus with one cycle
// of latency. LD/ST ops start a req/ack access on the data-memory port and
// stall the execute stage (mem_stall) until the access completes.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a BUSY watchdog aborts an access after TIMEOUT_CYCLES cycles
//   without ack. The aborted op is returned with result 16'hFFFF and mem_fault
//   pulses for one cycle. When undefined, BUSY waits indefinitely and
//   mem_fault is constant 0.
//
// Ports:
//   clock       in   1  system clock, rising edge
//   reset       in   1  synchronous active-high reset
//   exbus       in  40  {valid, op[3:0], dest[2:0], exresult[15:0], stvalue[15:0]}
//   mem_stall   out  1  execute stage must hold exbus while 1
//   mem_dest    out  3  exbus dest, combinational (hazard detection)
//   membus      out 24  {valid, op[3:0], dest[2:0], result[15:0]}, registered
//   dmem_req    out  1  access request, registered
//   dmem_we     out  1  1 = store, 0 = load
//   dmem_addr   out 16  word address
//   dmem_wdata  out 16  store data
//   dmem_ack    in   1  access complete (only looked at in BUSY)
//   dmem_rdata  in  16  load data, valid with dmem_ack
//   mem_fault   out  1  one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module mem_module #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [39:0] exbus,
   output logic        mem_stall,
   output logic [2:0]  mem_dest,
   output logic [23:0] membus,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [15:0] dmem_rdata,
   output logic        mem_fault
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   localparam logic [3:0] OP_LD = 4'd10;
   localparam logic [3:0] OP_ST = 4'd11;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
`endif

   // exbus field split
   logic        ex_valid;
   logic [3:0]  ex_op;
   logic [2:0]  ex_dest;
   logic [15:0] ex_result;
   logic [15:0] ex_stvalue;
   logic        ex_is_mem;

   assign ex_valid   = exbus[39];
   assign ex_op      = exbus[38:35];
   assign ex_dest    = exbus[34:32];
   assign ex_result  = exbus[31:16];
   assign ex_stvalue = exbus[15:0];
   assign ex_is_mem  = (ex_op == OP_LD) || (ex_op == OP_ST);

   state_e      state_q,  state_d;
   logic [23:0] membus_q, membus_d;
   logic        req_q,    req_d;
   logic        we_q,     we_d;
   logic [15:0] addr_q,   addr_d;
   logic [15:0] wdata_q,  wdata_d;
   logic [3:0]  op_q,     op_d;
   logic [2:0]  dest_q,   dest_d;
   logic        fault_q,  fault_d;
`ifdef MEM_TIMEOUT_EN
   logic [7:0]  cnt_q,    cnt_d;
`endif

   // Next-state and next-output logic for the IDLE/BUSY access FSM
   always_comb begin
      state_d  = state_q;
      membus_d = membus_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      op_d     = op_q;
      dest_d   = dest_q;
      fault_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (ex_valid && ex_is_mem) begin
               // Latch the access; the address doubles as the ST result later.
               op_d     = ex_op;
               dest_d   = ex_dest;
               req_d    = 1'b1;
               we_d     = (ex_op == OP_ST);
               addr_d   = ex_result;
               wdata_d  = ex_stvalue;
               membus_d = {1'b0, ex_op, ex_dest, ex_result};
               state_d  = ST_BUSY;
`ifdef MEM_TIMEOUT_EN
               cnt_d    = 8'd0;
`endif
            end else begin
               // Pass-through; valid = 0 propagates as a bubble.
               req_d    = 1'b0;
               membus_d = {ex_valid, ex_op, ex_dest, ex_result};
            end
         end
         ST_BUSY: begin
            if (dmem_ack) begin
               // Ack wins over a simultaneous watchdog expiry.
               req_d   = 1'b0;
               state_d = ST_IDLE;
               if (op_q == OP_LD) begin
                  membus_d = {1'b1, op_q, dest_q, dmem_rdata};
               end else begin
                  membus_d = {1'b1, op_q, dest_q, addr_q};
               end
`ifdef MEM_TIMEOUT_EN
            end else if ((cnt_q + 8'd1) == TIMEOUT_LIMIT) begin
               req_d    = 1'b0;
               state_d  = ST_IDLE;
               membus_d = {1'b1, op_q, dest_q, 16'hFFFF};
               fault_d  = 1'b1;
`endif
            end else begin
               membus_d = {1'b0, membus_q[22:0]};
`ifdef MEM_TIMEOUT_EN
               cnt_d    = cnt_q + 8'd1;
`endif
            end
         end
         default: begin
            state_d  = ST_IDLE;
            req_d    = 1'b0;
            membus_d = 24'd0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         membus_q <= 24'd0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 16'd0;
         wdata_q  <= 16'd0;
         op_q     <= 4'd0;
         dest_q   <= 3'd0;
         fault_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q    <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         membus_q <= membus_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         op_q     <= op_d;
         dest_q   <= dest_d;
         fault_q  <= fault_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign mem_stall  = (state_q == ST_BUSY);
   assign mem_dest   = ex_dest;
   assign membus     = membus_q;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign mem_fault  = fault_q;

endmodule

// File: tb/tb_mem_module.sv
// -----------------------------------------------------------------------------
// tb_mem_module : self-checking bench for mem_module.
// Directed scenarios followed by random instruction traffic. Expected values
// come from a transaction-level model: a word array for data memory, and the
// rule that each instruction's result appears one cycle after issue (non-mem)
// or one cycle after the ack edge (LD/ST).
// -----------------------------------------------------------------------------
module tb_mem_module;

   localparam logic [3:0] LD  = 4'd10;
   localparam logic [3:0] ST  = 4'd11;
   localparam logic [3:0] ADD = 4'd1;
   localparam logic [3:0] SUB = 4'd2;
`ifdef MEM_TIMEOUT_EN
   localparam int MAXW = 3;
`else
   localparam int MAXW = 6;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [39:0] exbus = 40'd0;
   logic        mem_stall;
   logic [2:0]  mem_dest;
   logic [23:0] membus;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [15:0] dmem_rdata = 16'd0;
   logic        mem_fault;

   int checks = 0;
   int errors = 0;
   logic [15:0] mem_model [0:255];

   mem_module #(.TIMEOUT_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .exbus(exbus),
      .mem_stall(mem_stall), .mem_dest(mem_dest), .membus(membus),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .mem_fault(mem_fault)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one instruction; for LD/ST the ack arrives in BUSY cycle wait_n+1.
   task automatic issue(input logic v, input logic [3:0] op, input logic [2:0] dest,
                        input logic [15:0] res, input logic [15:0] stv, input int wait_n);
      logic [15:0] exp_res;
      exbus = {v, op, dest, res, stv};
      if (v && (op == LD || op == ST)) begin
         dmem_ack = 1'b0;
         tick();
         for (int k = 0; k <= wait_n; k++) begin
            chk("busy_stall", {23'd0, mem_stall}, 24'd1);
            chk("busy_req",   {23'd0, dmem_req},  24'd1);
            chk("busy_we",    {23'd0, dmem_we},   {23'd0, op == ST});
            chk("busy_addr",  {8'd0, dmem_addr},  {8'd0, res});
            chk("busy_wdata", {8'd0, dmem_wdata}, {8'd0, stv});
            chk("busy_bubble", {23'd0, membus[23]}, 24'd0);
            chk("busy_dest",  {21'd0, mem_dest},  {21'd0, dest});
            chk("busy_fault", {23'd0, mem_fault}, 24'd0);
            if (k == wait_n) begin
               dmem_ack   = 1'b1;
               dmem_rdata = (op == LD) ? mem_model[res[7:0]] : 16'($urandom);
            end else begin
               dmem_ack   = 1'b0;
               dmem_rdata = 16'($urandom);
            end
            tick();
         end
         dmem_ack = 1'b0;
         if (op == LD) begin
            exp_res = mem_model[res[7:0]];
         end else begin
            exp_res = res;
            mem_model[res[7:0]] = stv;
         end
         chk("mem_result", membus, {1'b1, op, dest, exp_res});
      end else begin
         // A stray ack while IDLE must have no effect.
         dmem_ack   = 1'($urandom_range(0, 1));
         dmem_rdata = 16'($urandom);
         tick();
         dmem_ack = 1'b0;
         chk("pass_result", membus, {v, op, dest, res});
      end
      chk("done_stall", {23'd0, mem_stall}, 24'd0);
      chk("done_req",   {23'd0, dmem_req},  24'd0);
      chk("done_fault", {23'd0, mem_fault}, 24'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      chk("rst_membus", membus, 24'd0);
      chk("rst_req",    {23'd0, dmem_req},  24'd0);
      chk("rst_stall",  {23'd0, mem_stall}, 24'd0);
      chk("rst_we",     {23'd0, dmem_we},   24'd0);
      chk("rst_addr",   {8'd0, dmem_addr},  24'd0);
      chk("rst_wdata",  {8'd0, dmem_wdata}, 24'd0);
      chk("rst_fault",  {23'd0, mem_fault}, 24'd0);
      reset = 1'b0;

      // 1: ADD pass-through
      issue(1'b1, ADD, 3'd3, 16'h1234, 16'h0000, 0);
      chk("t1_membus", membus, 24'h8B1234);

      // 2: LD with ack in the third BUSY cycle
      mem_model[8'h40] = 16'hBEEF;
      issue(1'b1, LD, 3'd5, 16'h0040, 16'h0000, 2);
      chk("t2_membus", membus, {1'b1, 4'd10, 3'd5, 16'hBEEF});

      // 3: ST with immediate ack, then SUB
      issue(1'b1, ST, 3'd2, 16'h0010, 16'h5A5A, 0);
      chk("t3_membus", membus, {1'b1, 4'd11, 3'd2, 16'h0010});
      issue(1'b1, SUB, 3'd6, 16'h0F0F, 16'h0000, 0);

      // 4: LD, LD, ADD back to back with zero wait
      issue(1'b1, LD,  3'd1, 16'h0010, 16'h0000, 0);
      chk("t4_ld_after_st", membus, {1'b1, 4'd10, 3'd1, 16'h5A5A});
      issue(1'b1, LD,  3'd4, 16'h0040, 16'h0000, 0);
      issue(1'b1, ADD, 3'd7, 16'hCAFE, 16'h0000, 0);

      // 5: reset while BUSY, then a late ack
      exbus = {1'b1, LD, 3'd3, 16'h0022, 16'h0000};
      tick();
      chk("t5_busy", {23'd0, mem_stall}, 24'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_req",    {23'd0, dmem_req},  24'd0);
      chk("t5_stall",  {23'd0, mem_stall}, 24'd0);
      chk("t5_membus", membus, 24'd0);
      exbus      = 40'd0;
      dmem_ack   = 1'b1;
      dmem_rdata = 16'hDEAD;
      tick();
      dmem_ack = 1'b0;
      chk("t5_late_ack_membus", membus, 24'd0);
      chk("t5_late_ack_stall",  {23'd0, mem_stall}, 24'd0);

      // Random traffic, including unknown ops and bubbles
      for (int n = 0; n < 60; n++) begin
         logic [3:0] r_op;
         logic       r_v;
         r_op = 4'($urandom_range(0, 15));
         if (n % 3 == 0) r_op = (n % 2 == 0) ? LD : ST;
         r_v = ($urandom_range(0, 7) != 0);
         issue(r_v, r_op, 3'($urandom), {8'd0, 8'($urandom_range(0, 15))},
               16'($urandom), $urandom_range(0, MAXW));
      end

`ifdef MEM_TIMEOUT_EN
      // 6: watchdog abort after 4 BUSY cycles
      exbus    = {1'b1, LD, 3'd6, 16'h0033, 16'h0000};
      dmem_ack = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("t6_req",   {23'd0, dmem_req},  24'd1);
         chk("t6_stall", {23'd0, mem_stall}, 24'd1);
         chk("t6_nofault", {23'd0, mem_fault}, 24'd0);
         tick();
      end
      chk("t6_membus", membus, {1'b1, 4'd10, 3'd6, 16'hFFFF});
      chk("t6_fault",  {23'd0, mem_fault}, 24'd1);
      chk("t6_req_off", {23'd0, dmem_req}, 24'd0);
      chk("t6_idle",   {23'd0, mem_stall}, 24'd0);
      issue(1'b0, 4'd0, 3'd0, 16'h0000, 16'h0000, 0);
      // Ack on the timeout cycle completes normally
      mem_model[8'h05] = 16'h1357;
      issue(1'b1, LD, 3'd2, 16'h0005, 16'h0000, 3);
      chk("t6_ack_wins", membus, {1'b1, 4'd10, 3'd2, 16'h1357});
`else
      // Long wait must not abort without the watchdog
      issue(1'b1, LD, 3'd2, 16'h0040, 16'h0000, 20);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_module.md
Name: mem_module

Overview:
- Memory-access stage directly downstream of the execute stage; consumes its registered 40-bit exbus.
- Non-memory results pass through with 1-cycle latency.
- LD/ST ops drive a req/ack data-memory port and stall the execute stage until the access completes.
- Produces the 24-bit membus consumed by writeback.

Parameters:
TIMEOUT_CYCLES, 16, max BUSY cycles before a watchdog abort (only used with MEM_TIMEOUT_EN); legal range 1..255.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous active-high reset
exbus  input  40  {valid[39], op[38:35], dest[34:32], exresult[31:16], stvalue[15:0]}
mem_stall  output  1  execute stage must hold exbus while 1
mem_dest  output  3  exbus[34:32], combinational, for hazard detection
membus  output  24  {valid[23], op[22:19], dest[18:16], result[15:0]}, registered
dmem_req  output  1  access request, registered
dmem_we  output  1  1 = store, 0 = load; valid while dmem_req
dmem_addr  output  16  word address (exresult of LD/ST)
dmem_wdata  output  16  store data (stvalue)
dmem_ack  input  1  access complete; sampled only in BUSY
dmem_rdata  input  16  load data, valid in the dmem_ack cycle
mem_fault  output  1  1-cycle pulse on watchdog abort; tied 0 without MEM_TIMEOUT_EN

Behaviour:
- Op encodings: NOP 0, ADD 1, SUB 2, AND 3, OR 4, NOT 5, SL 6, SR 7, SRU 8, ADDI 9, LD 10, ST 11, BR 12.
- Reset (synchronous, wins over all else):
  - state = IDLE.
  - membus, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_fault = 0.
  - Any in-flight access is dropped; no membus output is produced for it.
- FSM states: IDLE, BUSY. mem_stall = (state == BUSY), including the ack cycle. This guarantees the instruction held on exbus is processed only after return to IDLE.
- IDLE, exbus valid = 0:
  - membus <= {0, op, dest, exresult}; valid = 0 is a bubble.
- IDLE, valid = 1, op not LD/ST:
  - membus <= {1, op, dest, exresult}; 1-cycle latency.
  - Unknown ops pass through unchanged.
- IDLE, valid = 1, op LD or ST:
  - Latch op, dest, address and store data.
  - dmem_req <= 1; dmem_we <= (op == ST); dmem_addr <= exresult; dmem_wdata <= stvalue.
  - membus valid <= 0; state -> BUSY.
- BUSY, dmem_ack = 0:
  - Hold dmem_req and all dmem_* outputs stable.
  - membus valid <= 0.
- BUSY, dmem_ack = 1:
  - dmem_req <= 0; state -> IDLE.
  - LD: membus <= {1, LD, dest, dmem_rdata}.
  - ST: membus <= {1, ST, dest, address}; writeback ignores it.
- Ack timing: ack in the first BUSY cycle is legal, giving a minimum of 1 BUSY cycle. Load-to-membus latency = 2 cycles + ack wait.
- Exbus is ignored while BUSY. The execute stage holds it because mem_stall = 1.
- dmem_ack while IDLE is ignored; no state change.
- mem_dest always reflects the current exbus dest, including while BUSY.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter, cleared on BUSY entry and incremented each BUSY cycle without ack.
  - On the cycle it reaches TIMEOUT_CYCLES with no ack:
    - dmem_req <= 0; state -> IDLE.
    - membus <= {1, op, dest, 16'hFFFF}.
    - mem_fault <= 1 for exactly one cycle.
  - An ack in the same cycle as the timeout wins as a normal completion; no fault.
- Undefined: BUSY waits indefinitely; no counter; mem_fault constant 0.

Test Plan:
1. Reset, then exbus = {1, ADD, 3, 16'h1234, 0} -> next cycle membus = {1, 1, 3, 16'h1234}; mem_stall = 0; dmem_req = 0.
2. LD at addr 16'h0040 with ack 3 cycles after req rises, rdata 16'hBEEF -> dmem_req high 3 cycles with we = 0 and addr 0040; mem_stall high throughout BUSY; then membus = {1, 10, dest, BEEF}.
3. ST addr 16'h0010, stvalue 16'h5A5A, ack in first BUSY cycle -> one req cycle with we = 1, wdata 5A5A; membus = {1, 11, dest, 0010}. A following SUB held on exbus emerges the cycle after.
4. Back-to-back LD, LD, ADD with 0-wait acks -> three valid membus words in order, with exactly one bubble per load; no instruction lost or duplicated.
5. Reset asserted mid-BUSY -> next cycle dmem_req = 0, mem_stall = 0, membus = 0; a late dmem_ack is ignored.
6. (MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4) LD with no ack -> after 4 BUSY cycles, membus result = FFFF valid, mem_fault pulses 1 cycle, state returns to IDLE.
